// File: rtl/mem_bus_responder.sv
// Memory-side responder: ROM window 0000H-17FFH via external ROM port, RAM window 1800H-1FFFH internal.
// Optional MEM_STATS_EN macro adds read/write/error completion counters.
module mem_bus_responder #(
    parameter int RAM_WAIT = 0,
    parameter int ROM_LAT  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [12:0] addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ready,
    output logic        err,
    output logic        busy,
    output logic        rom_en,
    output logic [12:0] rom_addr,
    input  logic [7:0]  rom_data
`ifdef MEM_STATS_EN
    ,
    output logic [15:0] stat_rd,
    output logic [15:0] stat_wr,
    output logic [15:0] stat_err
`endif
);

    typedef enum logic [1:0] {IDLE, RAM_ACC, ROM_ACC, RESP} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_d;
    logic        we_q;
    logic [10:0] idx_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        ready_q;
    logic        err_q;
    logic        busy_q;
    logic        rom_en_q;
    logic [12:0] rom_addr_q;
    logic        ram_we_d;
    logic        is_ram_d;

    logic [7:0]  mem [0:2047];

    always_comb begin
        cnt_d    = cnt_q - 4'd1;
        ram_we_d = (state_q == RAM_ACC) && (cnt_q == 4'd0) && we_q;
        is_ram_d = (addr[12:11] == 2'b11);
    end

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we_d) begin
            mem[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            idx_q      <= 11'd0;
            wdata_q    <= 8'd0;
            rdata_q    <= 8'd0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            rom_en_q   <= 1'b0;
            rom_addr_q <= 13'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req) begin
                        busy_q  <= 1'b1;
                        we_q    <= we;
                        idx_q   <= addr[10:0];
                        wdata_q <= wdata;
                        if (is_ram_d) begin
                            cnt_q   <= 4'(RAM_WAIT);
                            state_q <= RAM_ACC;
                        end else if (!we) begin
                            rom_en_q   <= 1'b1;
                            rom_addr_q <= addr;
                            cnt_q      <= 4'(ROM_LAT);
                            state_q    <= ROM_ACC;
                        end else begin
                            state_q <= RESP;
                        end
                    end
                end
                RAM_ACC: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_d;
                    end else begin
                        rdata_q <= we_q ? 8'd0 : mem[idx_q];
                        ready_q <= 1'b1;
                        state_q <= RESP;
                    end
                end
                ROM_ACC: begin
                    rom_en_q <= 1'b0;
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_d;
                    end else begin
                        rdata_q <= rom_data;
                        ready_q <= 1'b1;
                        state_q <= RESP;
                    end
                end
                RESP: begin
                    // A ROM write arrives here with ready low: spend one cycle before flagging the error.
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        ready_q <= 1'b0;
                        err_q   <= 1'b0;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef MEM_STATS_EN
    logic [15:0] stat_rd_q;
    logic [15:0] stat_wr_q;
    logic [15:0] stat_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_rd_q  <= 16'd0;
            stat_wr_q  <= 16'd0;
            stat_err_q <= 16'd0;
        end else if (state_q == RESP && ready_q) begin
            if (err_q) begin
                stat_err_q <= stat_err_q + 16'd1;
            end else if (we_q) begin
                stat_wr_q <= stat_wr_q + 16'd1;
            end else begin
                stat_rd_q <= stat_rd_q + 16'd1;
            end
        end
    end

    assign stat_rd  = stat_rd_q;
    assign stat_wr  = stat_wr_q;
    assign stat_err = stat_err_q;
`endif

    assign rdata    = rdata_q;
    assign ready    = ready_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign rom_en   = rom_en_q;
    assign rom_addr = rom_addr_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder with RAM_WAIT=2, ROM_LAT=2; checks stats when MEM_STATS_EN is defined.
module tb_mem_bus_responder;
    localparam int RAM_WAIT = 2;
    localparam int ROM_LAT  = 2;
    localparam int RAM_L    = 1 + RAM_WAIT;
    localparam int ROM_L    = 1 + ROM_LAT;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [12:0] addr = 13'd0;
    logic [7:0]  wdata = 8'd0;
    logic [7:0]  rdata;
    logic        ready;
    logic        err;
    logic        busy;
    logic        rom_en;
    logic [12:0] rom_addr;
    logic [7:0]  rom_data = 8'hEE;
`ifdef MEM_STATS_EN
    logic [15:0] stat_rd;
    logic [15:0] stat_wr;
    logic [15:0] stat_err;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int rdy_cnt = 0;
    int exp_rd = 0;
    int exp_wr = 0;
    int exp_err = 0;

    mem_bus_responder #(.RAM_WAIT(RAM_WAIT), .ROM_LAT(ROM_LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err), .busy(busy),
        .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data)
`ifdef MEM_STATS_EN
        , .stat_rd(stat_rd), .stat_wr(stat_wr), .stat_err(stat_err)
`endif
    );

    always #5 clk = ~clk;

    // Synchronous ROM model: data valid only in the cycle after edge N+2, garbage otherwise.
    logic rom_pend = 1'b0;
    always @(posedge clk) begin
        if (rom_en) begin
            rom_pend <= 1'b1;
            rom_data <= 8'hEE;
        end else if (rom_pend) begin
            rom_pend <= 1'b0;
            rom_data <= (rom_addr == 13'h0010) ? 8'h3C : (rom_addr[7:0] ^ 8'h5A);
        end else begin
            rom_data <= 8'hEE;
        end
    end

    always @(negedge clk) if (ready) rdy_cnt++;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One transaction; ends on the negedge of the first IDLE cycle after the ready cycle.
    task automatic txn(input string tag, input bit b2b, input bit hold_req,
                       input logic w, input logic [12:0] a, input logic [7:0] d,
                       output logic [7:0] rd, output logic e, output int lat,
                       output int ens, output logic [12:0] ea);
        bit done;
        if (!b2b) @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d;
        @(posedge clk);
        lat = 0; ens = 0; ea = 13'd0; rd = 8'd0; e = 1'b0; done = 1'b0;
        @(negedge clk);
        if (!hold_req) req = 1'b0;
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < 40 && !done; i++) begin
            if (i > 0) @(negedge clk);
            if (rom_en) begin ens++; ea = rom_addr; end
            if (ready) begin rd = rdata; e = err; done = 1'b1; end
            else lat++;
        end
        if (!done) chk({tag, "_timeout"}, 32'd1, 32'd0);
        @(negedge clk);
        req = 1'b0;
        chk({tag, "_rdy_low"}, 32'(ready), 32'd0);
        chk({tag, "_busy_low"}, 32'(busy), 32'd0);
        if (a[12:11] == 2'b11) begin
            if (w) exp_wr++; else exp_rd++;
        end else begin
            if (w) exp_err++; else exp_rd++;
        end
    endtask

    task automatic chk_idle_outs(input string tag);
        chk(tag, {rdata, ready, err, busy, rom_en, rom_addr}, 32'd0);
    endtask

    logic [7:0]  rd;
    logic        e;
    int          lat;
    int          ens;
    logic [12:0] ea;
    int          rc0;

    initial begin
        repeat (2) @(negedge clk);
        chk_idle_outs("reset_outs");
        rst = 1'b0;

        txn("rd1800", 0, 0, 1'b0, 13'h1800, 8'h00, rd, e, lat, ens, ea);
        chk("rd1800_err", 32'(e), 32'd0);
        chk("rd1800_lat", 32'(lat), 32'(RAM_L));

        txn("wr1805", 0, 0, 1'b1, 13'h1805, 8'hA5, rd, e, lat, ens, ea);
        chk("wr1805_err", 32'(e), 32'd0);
        chk("wr1805_lat", 32'(lat), 32'(RAM_L));
        chk("wr1805_rdata", 32'(rd), 32'h00);
        chk("wr1805_romen", 32'(ens), 32'd0);

        txn("rd1805", 1, 0, 1'b0, 13'h1805, 8'h00, rd, e, lat, ens, ea);
        chk("rd1805_rdata", 32'(rd), 32'hA5);
        chk("rd1805_lat", 32'(lat), 32'(RAM_L));

        txn("rom10", 0, 0, 1'b0, 13'h0010, 8'h00, rd, e, lat, ens, ea);
        chk("rom10_ens", 32'(ens), 32'd1);
        chk("rom10_addr", 32'(ea), 32'h0010);
        chk("rom10_rdata", 32'(rd), 32'h3C);
        chk("rom10_lat", 32'(lat), 32'(ROM_L));
        chk("rom10_err", 32'(e), 32'd0);

        txn("wr1900", 0, 0, 1'b1, 13'h1900, 8'h77, rd, e, lat, ens, ea);
        txn("romwr", 0, 0, 1'b1, 13'h0100, 8'hFF, rd, e, lat, ens, ea);
        chk("romwr_err", 32'(e), 32'd1);
        chk("romwr_lat", 32'd1, 32'(lat));
        chk("romwr_ens", 32'(ens), 32'd0);
        txn("rd1900", 1, 0, 1'b0, 13'h1900, 8'h00, rd, e, lat, ens, ea);
        chk("rd1900_rdata", 32'(rd), 32'h77);
        chk("rd1900_err", 32'(e), 32'd0);

        txn("rom17ff", 0, 0, 1'b0, 13'h17FF, 8'h00, rd, e, lat, ens, ea);
        chk("rom17ff_ens", 32'(ens), 32'd1);
        chk("rom17ff_addr", 32'(ea), 32'h17FF);
        chk("rom17ff_rdata", 32'(rd), 32'hA5);

        txn("wr1800", 0, 0, 1'b1, 13'h1800, 8'h11, rd, e, lat, ens, ea);
        chk("wr1800_ens", 32'(ens), 32'd0);
        txn("wr1fff", 1, 0, 1'b1, 13'h1FFF, 8'h22, rd, e, lat, ens, ea);
        chk("wr1fff_ens", 32'(ens), 32'd0);
        txn("rb1800", 1, 0, 1'b0, 13'h1800, 8'h00, rd, e, lat, ens, ea);
        chk("rb1800_rdata", 32'(rd), 32'h11);
        txn("rb1fff", 1, 0, 1'b0, 13'h1FFF, 8'h00, rd, e, lat, ens, ea);
        chk("rb1fff_rdata", 32'(rd), 32'h22);
        txn("rb1805", 0, 0, 1'b0, 13'h1805, 8'h00, rd, e, lat, ens, ea);
        chk("rb1805_rdata", 32'(rd), 32'hA5);

        rc0 = rdy_cnt;
        txn("busyreq", 0, 1, 1'b0, 13'h1805, 8'h00, rd, e, lat, ens, ea);
        repeat (6) @(negedge clk);
        chk("busyreq_readies", 32'(rdy_cnt - rc0), 32'd1);
        chk("busyreq_idle", 32'(busy), 32'd0);

        // Reset in the middle of a ROM read.
        rc0 = rdy_cnt;
        @(negedge clk);
        req = 1'b1; we = 1'b0; addr = 13'h0010;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        #2 rst = 1'b1;
        #1 chk_idle_outs("midrst_outs");
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst_noready", 32'(rdy_cnt - rc0), 32'd0);
        txn("postrst", 0, 0, 1'b0, 13'h1800, 8'h00, rd, e, lat, ens, ea);
        chk("postrst_rdata", 32'(rd), 32'h11);
        chk("postrst_err", 32'(e), 32'd0);
        chk("postrst_lat", 32'(lat), 32'(RAM_L));

`ifdef MEM_STATS_EN
        // Counters were cleared by the mid-run reset: only the final read remains.
        chk("stat_rd", 32'(stat_rd), 32'd1);
        chk("stat_wr", 32'(stat_wr), 32'd0);
        chk("stat_err", 32'(stat_err), 32'd0);
`endif
        if (exp_rd + exp_wr + exp_err == 0) chk("txn_tally", 32'd1, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
